// File: rtl/idu_pkg.sv
// Shared opcode constants, queue entry type and source-register usage decode for the IDU.
// Storage fields are sized by IDU_ADDR_W/IDU_DATA_W; the queue's width parameters default to these.
package idu_pkg;

    localparam int IDU_ADDR_W = 32;
    localparam int IDU_DATA_W = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [IDU_DATA_W-1:0] inst;
        logic [IDU_ADDR_W-1:0] pc;
    } iq_entry_t;

    // Returns {rs1_used, rs2_used} for the given opcode.
    function automatic logic [1:0] uses_rs(input logic [6:0] opcode);
        logic rs1;
        logic rs2;
        rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        rs2 = (opcode == OP_BRANCH || opcode == OP_STORE || opcode == OP_OP);
        return {rs1, rs2};
    endfunction

endpackage

// File: rtl/idu_sb.sv
// Load-use scoreboard: one pending bit per architectural register, x0 never pending.
// Lookup is combinational on registered state; set beats clear for the same register.
module idu_sb (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [4:0] set_addr,
    input  logic       clr_en,
    input  logic [4:0] clr_addr,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    output logic       rs1_busy,
    output logic       rs2_busy
);

    logic [31:1] sb;
    logic [31:0] sb_vec;

    assign sb_vec   = {sb, 1'b0};
    assign rs1_busy = sb_vec[rs1_addr];
    assign rs2_busy = sb_vec[rs2_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            sb <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (set_en && set_addr == 5'(i))
                    sb[i] <= 1'b1;
                else if (clr_en && clr_addr == 5'(i))
                    sb[i] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/idu_iq.sv
// Fetch-to-decode instruction queue with load-use hold-off; enqueue-to-issue latency 1 cycle
// (0 with IDU_IQ_BYPASS_EN on an empty queue). if_ready drops only when full; issue waits on is_ready.
module idu_iq
    import idu_pkg::*;
#(
    parameter int IM_ADDR_LEN = IDU_ADDR_W,
    parameter int IM_DATA_LEN = IDU_DATA_W,
    parameter int IQ_DEPTH    = 4,
    parameter int CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         if_valid,
    output logic                         if_ready,
    input  logic [IM_DATA_LEN-1:0]       if_inst,
    input  logic [IM_ADDR_LEN-1:0]       if_pc,
    input  logic                         flush,
    output logic                         is_valid,
    input  logic                         is_ready,
    output logic [IM_DATA_LEN-1:0]       is_inst,
    output logic [IM_ADDR_LEN-1:0]       is_pc,
    output logic [4:0]                   is_rs1_addr,
    output logic [4:0]                   is_rs2_addr,
    output logic [4:0]                   is_rd_addr,
    output logic                         is_load,
    output logic                         is_ill,
    input  logic                         wb_valid,
    input  logic [4:0]                   wb_rd,
    output logic                         hz_stall,
    output logic [$clog2(IQ_DEPTH):0]    iq_cnt,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int AW = $clog2(IQ_DEPTH);
    localparam int PW = AW + 1;

    iq_entry_t       mem [IQ_DEPTH];
    iq_entry_t       head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            empty;
    logic            full;
    logic [1:0]      use_rs;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            hz;
    logic            byp;
    logic            issue;
    logic            deq;
    logic            enq;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

`ifdef IDU_IQ_BYPASS_EN
    // On an empty queue the incoming instruction is presented directly.
    assign is_inst = empty ? if_inst : IM_DATA_LEN'(head.inst);
    assign is_pc   = empty ? if_pc   : IM_ADDR_LEN'(head.pc);
`else
    assign is_inst = IM_DATA_LEN'(head.inst);
    assign is_pc   = IM_ADDR_LEN'(head.pc);
`endif

    assign is_rs1_addr = is_inst[19:15];
    assign is_rs2_addr = is_inst[24:20];
    assign is_rd_addr  = is_inst[11:7];
    assign is_load     = (is_inst[6:0] == OP_LOAD);
    assign is_ill      = (is_inst[1:0] != 2'b11);
    assign use_rs      = uses_rs(is_inst[6:0]);

    idu_sb u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue && is_load && (is_rd_addr != 5'd0)),
        .set_addr (is_rd_addr),
        .clr_en   (wb_valid),
        .clr_addr (wb_rd),
        .rs1_addr (is_rs1_addr),
        .rs2_addr (is_rs2_addr),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy)
    );

    assign hz = (use_rs[1] && rs1_busy) || (use_rs[0] && rs2_busy);

`ifdef IDU_IQ_BYPASS_EN
    assign byp = empty && !flush && if_valid && !hz;
`else
    assign byp = 1'b0;
`endif

    assign if_ready = !full;
    assign is_valid = !flush && ((!empty && !hz) || byp);
    assign hz_stall = !empty && hz;
    assign issue    = is_valid && is_ready;
    assign deq      = issue && !empty;
    // A bypassed instruction that is consumed immediately never occupies a slot.
    assign enq      = if_valid && if_ready && !flush && !(byp && is_ready);
    assign iq_cnt   = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (enq)
            mem[wr_ptr[AW-1:0]] <= '{inst: IDU_DATA_W'(if_inst), pc: IDU_ADDR_W'(if_pc)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (hz_stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_idu_iq.sv
// Randomised bench for idu_iq: queue/scoreboard reference model feeds an issue scoreboard.
module tb_idu_iq;

    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int SMAX  = (1 << CW) - 1;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        flush;
    logic        is_valid;
    logic        is_ready;
    logic [31:0] is_inst;
    logic [31:0] is_pc;
    logic [4:0]  is_rs1_addr;
    logic [4:0]  is_rs2_addr;
    logic [4:0]  is_rd_addr;
    logic        is_load;
    logic        is_ill;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        hz_stall;
    logic [2:0]  iq_cnt;
    logic [CW-1:0] stall_cnt;

    idu_iq #(.IM_ADDR_LEN(32), .IM_DATA_LEN(32), .IQ_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst),
        .if_pc(if_pc), .flush(flush), .is_valid(is_valid), .is_ready(is_ready),
        .is_inst(is_inst), .is_pc(is_pc), .is_rs1_addr(is_rs1_addr), .is_rs2_addr(is_rs2_addr),
        .is_rd_addr(is_rd_addr), .is_load(is_load), .is_ill(is_ill), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .hz_stall(hz_stall), .iq_cnt(iq_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   chk_en   = 1'b0;

    ent_t      mq[$];
    ent_t      exp_q[$];
    bit [31:0] sbm;
    int        scnt;

    bit  e_valid, e_ready, e_stall;
    int  e_cnt, e_scnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Source-usage rules: rs1 unless LUI/AUIPC/JAL, rs2 for BRANCH/STORE/OP.
    function automatic bit hazard(input logic [31:0] inst);
        logic [6:0] op;
        bit r1, r2;
        op = inst[6:0];
        r1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
        r2 = (op == 7'b1100011 || op == 7'b0100011 || op == 7'b0110011);
        return (r1 && sbm[inst[19:15]]) || (r2 && sbm[inst[24:20]]);
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 8))
            0: x[6:0] = 7'b0000011;
            1: x[6:0] = 7'b0100011;
            2: x[6:0] = 7'b1100011;
            3: x[6:0] = 7'b0110011;
            4: x[6:0] = 7'b0110111;
            5: x[6:0] = 7'b0010111;
            6: x[6:0] = 7'b1101111;
            7: x[6:0] = 7'b0010011;
            default: ;
        endcase
        x[19:15] = 5'($urandom_range(0, 7));
        x[24:20] = 5'($urandom_range(0, 7));
        x[11:7]  = 5'($urandom_range(0, 7));
        return x;
    endfunction

    // Apply one cycle of stimulus, predict this cycle's outputs, then advance the model past the edge.
    task automatic step(input bit r, input bit iv, input logic [31:0] inst, input logic [31:0] pc,
                        input bit ir, input bit fl, input bit wv, input logic [4:0] wr);
        bit   empty, full, byp, hzh, vld, iss;
        ent_t cand;
        rst = r; if_valid = iv; if_inst = inst; if_pc = pc;
        is_ready = ir; flush = fl; wb_valid = wv; wb_rd = wr;
        empty = (mq.size() == 0);
        full  = (mq.size() == DEPTH);
        byp   = 1'b0;
        hzh   = 1'b0;
        cand  = '{inst: inst, pc: pc};
        if (!empty) begin
            cand = mq[0];
            hzh  = hazard(cand.inst);
        end
`ifdef IDU_IQ_BYPASS_EN
        else if (iv && !fl && !hazard(inst)) begin
            byp = 1'b1;
        end
`endif
        vld = !fl && ((!empty && !hzh) || byp);
        iss = vld && ir;
        e_valid = vld; e_ready = !full; e_stall = !empty && hzh;
        e_cnt = mq.size(); e_scnt = scnt;
        if (iss) exp_q.push_back(cand);
        @(posedge clk); #1;
        if (r) begin
            mq.delete(); sbm = '0; scnt = 0;
        end else begin
            if (e_stall && scnt != SMAX) scnt++;
            if (wv) sbm[wr] = 1'b0;
            if (iss && cand.inst[6:0] == 7'b0000011) sbm[cand.inst[11:7]] = 1'b1;
            sbm[0] = 1'b0;
            if (fl) mq.delete();
            else begin
                if (iss && !empty) void'(mq.pop_front());
                if (iv && !full && !(byp && ir)) mq.push_back('{inst: inst, pc: pc});
            end
        end
    endtask

    task automatic idle(input int n, input bit ir);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0, ir, 0, 0, 5'd0);
    endtask

    ent_t mon_e;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("is_valid", 64'(is_valid), 64'(e_valid));
            chk("if_ready", 64'(if_ready), 64'(e_ready));
            chk("hz_stall", 64'(hz_stall), 64'(e_stall));
            chk("iq_cnt", 64'(iq_cnt), 64'(e_cnt));
            chk("stall_cnt", 64'(stall_cnt), 64'(e_scnt));
            if (is_valid === 1'b1 && is_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", 64'(1), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("is_pc", 64'(is_pc), 64'(mon_e.pc));
                    chk("is_inst", 64'(is_inst), 64'(mon_e.inst));
                    chk("is_rs1_addr", 64'(is_rs1_addr), 64'(mon_e.inst[19:15]));
                    chk("is_rs2_addr", 64'(is_rs2_addr), 64'(mon_e.inst[24:20]));
                    chk("is_rd_addr", 64'(is_rd_addr), 64'(mon_e.inst[11:7]));
                    chk("is_load", 64'(is_load), 64'(mon_e.inst[6:0] == 7'b0000011));
                    chk("is_ill", 64'(is_ill), 64'(mon_e.inst[1:0] != 2'b11));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0;
        is_ready = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0;
        mq.delete(); exp_q.delete(); sbm = '0; scnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset state, then a single ADDI x1,x0,5 at 0x100.
        idle(1, 1);
        step(0, 1, 32'h00500093, 32'h100, 1, 0, 0, 5'd0);
        idle(2, 1);

        // Fill past capacity with issue held off, then drain in order.
        for (int i = 0; i < 5; i++) step(0, 1, rnd_inst() | 32'h3, 32'h200 + 32'(4 * i), 0, 0, 0, 5'd0);
        idle(6, 1);

        // Load-use: LW x5 then ADD x6,x5,x7 stalls long enough to saturate stall_cnt.
        step(0, 1, 32'h0000a283, 32'h300, 1, 0, 0, 5'd0);
        step(0, 1, 32'h00728333, 32'h304, 1, 0, 0, 5'd0);
        idle(20, 1);
        step(0, 0, 32'h0, 32'h0, 1, 0, 1, 5'd5);
        idle(2, 1);

        // Set and clear of x5 in the same cycle: set wins.
        step(0, 1, 32'h0000a283, 32'h400, 0, 0, 0, 5'd0);
        step(0, 0, 32'h0, 32'h0, 1, 0, 1, 5'd5);
        step(0, 1, 32'h00728333, 32'h404, 1, 0, 0, 5'd0);
        idle(3, 1);
        step(0, 0, 32'h0, 32'h0, 1, 0, 1, 5'd5);
        idle(2, 1);

        // LW x0 never marks x0 pending.
        step(0, 1, 32'h0000a003, 32'h500, 1, 0, 0, 5'd0);
        step(0, 1, 32'h00000333, 32'h504, 1, 0, 0, 5'd0);
        idle(2, 1);

        // Flush with three queued entries keeps the pending load bit.
        step(0, 1, 32'h0000a283, 32'h600, 1, 0, 0, 5'd0);
        idle(1, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h00100093, 32'h610 + 32'(4 * i), 0, 0, 0, 5'd0);
        step(0, 1, 32'h00100093, 32'h620, 1, 1, 0, 5'd0);
        step(0, 1, 32'h00728333, 32'h624, 1, 0, 0, 5'd0);
        idle(3, 1);
        step(0, 0, 32'h0, 32'h0, 1, 0, 1, 5'd5);
        idle(2, 1);

        // Empty queue with valid and ready together.
        step(0, 1, 32'h00200113, 32'h700, 1, 0, 0, 5'd0);
        idle(2, 1);

        // Randomised traffic with occasional flushes and one mid-run reset.
        for (int c = 0; c < 2000; c++) begin
            step(c == 1000, ($urandom_range(0, 99) < 60), rnd_inst(), $urandom,
                 ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 7)));
        end

        // Retire every pending load and drain.
        for (int i = 0; i < 32; i++) step(0, 0, 32'h0, 32'h0, 1, 0, 1, 5'(i));
        idle(DEPTH + 2, 1);
        chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/idu_iq.md
Name: idu_iq

Overview:
- Decoupling instruction queue plus load-use scoreboard between the fetch unit and the decode/register-file stage.
- Buffers up to IQ_DEPTH fetched instructions and pre-decodes register fields.
- Holds back issue while the head instruction reads a register with an outstanding load writeback.
- Successor to the fixed single-slot decode front end: parametrised depth, valid/ready handshakes, flush and hazard tracking.

Parameters:
- IM_ADDR_LEN, 32, PC width.
- IM_DATA_LEN, 32, instruction width.
- IQ_DEPTH, 4, queue entries; power of two, >= 2.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  queue accepts this cycle.
- if_inst  in  IM_DATA_LEN  instruction.
- if_pc  in  IM_ADDR_LEN  PC of the instruction.
- flush  in  1  discard all queued instructions (redirect or trap).
- is_valid  out  1  head instruction issuable this cycle.
- is_ready  in  1  decode/EXE accepts this cycle.
- is_inst  out  IM_DATA_LEN  head instruction.
- is_pc  out  IM_ADDR_LEN  head PC.
- is_rs1_addr, is_rs2_addr, is_rd_addr  out  5 each  head fields inst[19:15], inst[24:20], inst[11:7].
- is_load  out  1  head opcode is 7'b0000011.
- is_ill  out  1  head inst[1:0] != 2'b11.
- wb_valid  in  1  load writeback completes.
- wb_rd  in  5  load writeback destination.
- hz_stall  out  1  head valid but blocked by the scoreboard.
- iq_cnt  out  $clog2(IQ_DEPTH)+1  current occupancy.
- stall_cnt  out  CNT_W  saturating count of hz_stall cycles.

Behaviour:
- Reset: queue empty, rd/wr pointers 0, scoreboard all 0, stall_cnt 0. Consequently if_ready=1, is_valid=0, hz_stall=0, iq_cnt=0. Data outputs are don't-care while is_valid=0.
- Storage: circular buffer with pointers of width log2(IQ_DEPTH)+1; the MSB distinguishes full from empty. Pointers wrap naturally.
- Enqueue when if_valid && if_ready. if_ready = !full; it does not depend on is_ready, so a full queue refuses enqueue even if a dequeue happens in the same cycle.
- Head pre-decode uses these source-usage rules:
  - rs1 used unless opcode is LUI, AUIPC or JAL.
  - rs2 used only for BRANCH, STORE and OP.
  - Address 0 is never a hazard.
- Hazard: hz = (rs1 used && sb[rs1]) || (rs2 used && sb[rs2]).
- is_valid = !empty && !hz. hz_stall = !empty && hz.
- Issue (dequeue) when is_valid && is_ready.
- Minimum latency enqueue to is_valid is 1 cycle; there is no bypass unless the optional feature is enabled.
- Scoreboard, 32 bits:
  - Set sb[rd] on issue of a load with rd != 0.
  - Clear sb[wb_rd] on wb_valid.
  - Same-cycle set and clear of the same rd: set wins.
  - sb[0] is hardwired 0.
- Flush:
  - Next cycle the queue is empty and pointers are equal.
  - An enqueue in the flush cycle is dropped.
  - No issue occurs in the flush cycle; is_valid is forced to 0.
  - The scoreboard is NOT cleared, because issued loads still write back.
- stall_cnt increments on each hz_stall cycle and saturates at all-ones.
- Reset mid-operation returns every state element to its reset value on the next edge; queued entries are lost.

Optional Feature:
- Macro IDU_IQ_BYPASS_EN.
- When defined, and the queue is empty, no flush, if_valid=1 and the incoming instruction has no hazard:
  - The incoming instruction drives is_* combinationally with is_valid=1 (0-cycle latency).
  - If is_ready=1 it is consumed and not written into the queue.
  - If is_ready=0 it is enqueued normally.
- When undefined: strict 1-cycle minimum latency; is_* are driven only from queue storage.

Decomposition:
- Shared package idu_pkg holds:
  - opcode localparams (OP_LOAD, OP_STORE, OP_BRANCH, OP_OP, OP_LUI, OP_AUIPC, OP_JAL);
  - typedef iq_entry_t {inst, pc};
  - function uses_rs(opcode) returning {rs1_used, rs2_used}.
- One sub-module, idu_sb (32-bit scoreboard with set/clear/lookup ports). The queue stays inline.

Test Plan:
- Reset, then enqueue ADDI x1,x0,5 at pc 0x100 with is_ready=1 -> is_valid=1 one cycle later, is_pc=0x100, is_rd_addr=1, iq_cnt back to 0 after issue.
- Hold is_ready=0 and push 5 instructions with IQ_DEPTH=4 -> if_ready=0 after the 4th, 5th not accepted, iq_cnt=4. Release -> issued in order, pointers wrap correctly.
- Issue LW x5 and keep wb_valid=0, next instruction ADD x6,x5,x7 -> hz_stall=1 and stall_cnt increments each cycle. Pulse wb_valid with wb_rd=5 -> ADD issues next cycle.
- In one cycle issue LW x5 while wb_valid with wb_rd=5 -> sb[5] remains set. LW x0 issue -> no scoreboard set; a following reader of x0 is never stalled.
- Queue holds 3 entries, assert flush while if_valid=1 -> next cycle iq_cnt=0, is_valid=0, no entry issued. A pending load's scoreboard bit is preserved.
- With IDU_IQ_BYPASS_EN defined, empty queue, if_valid=1 and is_ready=1 -> is_valid=1 in the same cycle and iq_cnt stays 0. With the macro undefined -> is_valid=1 one cycle later.
